// File: rtl/cs_wcs_loader_if.sv
// rtl/cs_wcs_loader_if.sv - command, write-word and read-word handshakes of the WCS loader
interface cs_wcs_loader_if;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_WRITE;
    logic [11:0] CMD_ADDR;
    logic [7:0]  CMD_COUNT;
    logic        WD_VALID;
    logic        WD_READY;
    logic [15:0] WD;
    logic        RD_VALID;
    logic        RD_READY;
    logic [15:0] RD;

    modport master (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_COUNT, WD_VALID, WD, RD_READY,
        input  CMD_READY, WD_READY, RD_VALID, RD
    );

    modport slave (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_COUNT, WD_VALID, WD, RD_READY,
        output CMD_READY, WD_READY, RD_VALID, RD
    );
endinterface

// File: rtl/cs_wcs_loader.sv
// rtl/cs_wcs_loader.sv - writable control store load/readback sequencer
module cs_wcs_loader #(
    parameter int STB_CYCLES   = 2,
    parameter int SETUP_CYCLES = 1
) (
    input  logic                 sysclk,
    input  logic                 sys_rst,
    cs_wcs_loader_if.slave       bus,
    input  logic                 ABORT,
    input  logic [15:0]          CS_D_IN,
    output logic [15:0]          CS_D_OUT,
    output logic [11:0]          CSA,
    output logic [1:0]           RF_1_0,
    output logic                 WCSTB_n,
    output logic                 ECSD_n,
    output logic                 BUSY,
    output logic                 DONE
);

    typedef enum logic [2:0] {
        IDLE, WAIT_WD, SETUP, STROBE, HOLD, RSETUP, RWAIT
    } state_t;

    localparam logic [4:0] SETUP_LAST = 5'(SETUP_CYCLES - 1);
    localparam logic [4:0] STB_LAST   = 5'(STB_CYCLES - 1);
    localparam logic [4:0] RD_LAST    = 5'(SETUP_CYCLES + STB_CYCLES - 1);

    state_t      state, state_n;
    logic [4:0]  cnt;
    logic [8:0]  remaining;
    logic        dir;
    logic        abort_q;
    logic [15:0] rd_q;
    logic        advance;
    logic        finish;

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        advance = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE:    if (bus.CMD_VALID) state_n = bus.CMD_WRITE ? WAIT_WD : RSETUP;
            WAIT_WD: if (ABORT) begin state_n = IDLE; finish = 1'b1; end
                     else if (bus.WD_VALID) state_n = SETUP;
            SETUP:   if (ABORT) begin state_n = IDLE; finish = 1'b1; end
                     else if (cnt == SETUP_LAST) state_n = STROBE;
            // A strobe already on the wire always runs to full width.
            STROBE:  if (cnt == STB_LAST) state_n = HOLD;
            HOLD:    if (abort_q || ABORT) begin state_n = IDLE; finish = 1'b1; end
                     else advance = 1'b1;
            RSETUP:  if (ABORT) begin state_n = IDLE; finish = 1'b1; end
                     else if (cnt == RD_LAST) state_n = RWAIT;
            RWAIT:   if (ABORT) begin state_n = IDLE; finish = 1'b1; end
                     else if (bus.RD_READY) advance = 1'b1;
            default: state_n = IDLE;
        endcase
        if (advance) begin
            if (RF_1_0 == 2'd3 && remaining == 9'd1) begin
                state_n = IDLE;
                finish  = 1'b1;
            end else begin
                state_n = dir ? WAIT_WD : RSETUP;
            end
        end
    end

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt       <= '0;
            remaining <= '0;
            dir       <= 1'b0;
            abort_q   <= 1'b0;
            rd_q      <= '0;
            CS_D_OUT  <= '0;
            CSA       <= '0;
            RF_1_0    <= '0;
            DONE      <= 1'b0;
        end else begin
            cnt  <= (state_n != state) ? 5'd0 : cnt + 5'd1;
            DONE <= finish;
            if (state == IDLE)
                abort_q <= 1'b0;
            else if (state == STROBE && ABORT)
                abort_q <= 1'b1;
            if (state == IDLE && bus.CMD_VALID) begin
                CSA       <= bus.CMD_ADDR;
                remaining <= (bus.CMD_COUNT == 8'd0) ? 9'd256 : {1'b0, bus.CMD_COUNT};
                dir       <= bus.CMD_WRITE;
                RF_1_0    <= 2'd0;
            end
            if (state == WAIT_WD && bus.WD_VALID && !ABORT)
                CS_D_OUT <= bus.WD;
            if (state == RSETUP && cnt == RD_LAST && !ABORT)
                rd_q <= CS_D_IN;
            if (advance) begin
                if (RF_1_0 != 2'd3) begin
                    RF_1_0 <= RF_1_0 + 2'd1;
                end else begin
                    RF_1_0    <= 2'd0;
                    CSA       <= CSA + 12'd1;
                    remaining <= remaining - 9'd1;
                end
            end
        end
    end

    // Every handshake and strobe output is a pure decode of the state register.
    assign bus.CMD_READY = (state == IDLE);
    assign bus.WD_READY  = (state == WAIT_WD);
    assign bus.RD_VALID  = (state == RWAIT);
    assign bus.RD        = rd_q;
    assign BUSY          = (state != IDLE);
    assign WCSTB_n       = (state != STROBE);
    assign ECSD_n        = (state != RSETUP);

endmodule

// File: tb/tb_cs_wcs_loader.sv
// tb/tb_cs_wcs_loader.sv - randomized self-checking bench for cs_wcs_loader
module tb_cs_wcs_loader;
    localparam int S = 1;
    localparam int T = 2;

    logic        sysclk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        ABORT = 1'b0;
    logic [15:0] CS_D_IN = '0;
    logic [15:0] CS_D_OUT;
    logic [11:0] CSA;
    logic [1:0]  RF_1_0;
    logic        WCSTB_n, ECSD_n, BUSY, DONE;

    cs_wcs_loader_if bus();

    cs_wcs_loader #(.STB_CYCLES(T), .SETUP_CYCLES(S)) dut (
        .sysclk(sysclk), .sys_rst(sys_rst), .bus(bus), .ABORT(ABORT),
        .CS_D_IN(CS_D_IN), .CS_D_OUT(CS_D_OUT), .CSA(CSA), .RF_1_0(RF_1_0),
        .WCSTB_n(WCSTB_n), .ECSD_n(ECSD_n), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int failures = 0;
    logic [15:0] wq[$];
    logic [15:0] rq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_cmd_ready"}, 32'(bus.CMD_READY), 1);
        check_eq({tag, "_wd_ready"},  32'(bus.WD_READY), 0);
        check_eq({tag, "_rd_valid"},  32'(bus.RD_VALID), 0);
        check_eq({tag, "_busy"},      32'(BUSY), 0);
        check_eq({tag, "_done"},      32'(DONE), 0);
        check_eq({tag, "_wcstb"},     32'(WCSTB_n), 1);
        check_eq({tag, "_ecsd"},      32'(ECSD_n), 1);
        check_eq({tag, "_rf"},        32'(RF_1_0), 0);
        check_eq({tag, "_csa"},       32'(CSA), 0);
        check_eq({tag, "_dout"},      32'(CS_D_OUT), 0);
        check_eq({tag, "_rd"},        32'(bus.RD), 0);
    endtask

    task automatic issue_cmd(input logic wr, input logic [11:0] addr, input logic [7:0] count);
        @(negedge sysclk);
        while (!bus.CMD_READY) @(negedge sysclk);
        bus.CMD_VALID = 1'b1; bus.CMD_WRITE = wr; bus.CMD_ADDR = addr; bus.CMD_COUNT = count;
        @(negedge sysclk);
        bus.CMD_VALID = 1'b0;
    endtask

    // Model: word i of the transfer lives at CSA=addr+i/4, RF=i%4.
    task automatic do_write(input logic [11:0] addr, input logic [7:0] count, input int bp);
        int total, sent, idx, run;
        logic done_seen;
        logic [11:0] ea;
        total = (count == 0 ? 256 : int'(count)) * 4;
        while (wq.size() < total) wq.push_back(16'($urandom));
        issue_cmd(1'b1, addr, count);
        check_eq("wd_ready_latency", 32'(bus.WD_READY), 1);
        sent = 0; idx = 0; run = 0; done_seen = 1'b0;
        for (int cyc = 0; cyc < total * 12 + 50 && !done_seen; cyc++) begin
            if (!WCSTB_n) begin
                if (run == 0) begin
                    ea = addr + 12'(idx / 4);
                    check_eq("wr_csa", 32'(CSA), 32'(ea));
                    check_eq("wr_rf", 32'(RF_1_0), 32'(idx % 4));
                    check_eq("wr_data", 32'(CS_D_OUT), 32'(wq[idx]));
                end
                run++;
            end else if (run != 0) begin
                check_eq("stb_width", 32'(run), 32'(T));
                idx++; run = 0;
            end
            check_eq("strobe_excl", 32'(WCSTB_n | ECSD_n), 1);
            if (DONE) begin
                done_seen = 1'b1;
                check_eq("wr_strobes", 32'(idx), 32'(total));
                check_eq("wr_final_csa", 32'(CSA), 32'(12'(addr + 12'(total / 4))));
                check_eq("wr_final_rf", 32'(RF_1_0), 0);
                check_eq("wr_done_ready", 32'(bus.CMD_READY), 1);
            end else begin
                bus.WD_VALID = (sent < total) && ($urandom_range(0, 99) >= bp);
                if (sent < total) bus.WD = wq[sent];
                if (bus.WD_VALID && bus.WD_READY) sent++;
                @(negedge sysclk);
            end
        end
        bus.WD_VALID = 1'b0;
        check_eq("wr_done_seen", 32'(done_seen), 1);
        @(negedge sysclk);
        check_eq("wr_done_pulse", 32'(DONE), 0);
        wq.delete();
    endtask

    task automatic do_read(input logic [11:0] addr, input logic [7:0] count, input int bp, input logic stall);
        int total, ridx, run, stalled;
        logic done_seen;
        logic [11:0] ea;
        total = (count == 0 ? 256 : int'(count)) * 4;
        while (rq.size() < total) rq.push_back(16'($urandom));
        CS_D_IN = rq[0];
        issue_cmd(1'b0, addr, count);
        ridx = 0; run = 0; stalled = 0; done_seen = 1'b0;
        for (int cyc = 0; cyc < total * 40 + 50 && !done_seen; cyc++) begin
            if (!ECSD_n) begin
                if (run == 0) begin
                    ea = addr + 12'(ridx / 4);
                    check_eq("rd_csa", 32'(CSA), 32'(ea));
                    check_eq("rd_rf", 32'(RF_1_0), 32'(ridx % 4));
                end
                run++;
            end else if (run != 0) begin
                check_eq("ecsd_width", 32'(run), 32'(S + T));
                check_eq("rd_valid_rise", 32'(bus.RD_VALID), 1);
                run = 0;
            end
            check_eq("strobe_excl", 32'(WCSTB_n | ECSD_n), 1);
            if (bus.RD_VALID) check_eq("rd_data", 32'(bus.RD), 32'(rq[ridx]));
            if (DONE) begin
                done_seen = 1'b1;
                check_eq("rd_words", 32'(ridx), 32'(total));
                check_eq("rd_final_csa", 32'(CSA), 32'(12'(addr + 12'(total / 4))));
            end else begin
                if (stall && ridx == 0 && bus.RD_VALID && stalled < 10) begin
                    check_eq("stall_ecsd", 32'(ECSD_n), 1);
                    check_eq("stall_rf", 32'(RF_1_0), 0);
                    bus.RD_READY = 1'b0;
                    stalled++;
                end else begin
                    bus.RD_READY = ($urandom_range(0, 99) >= bp);
                end
                if (bus.RD_VALID && bus.RD_READY) ridx++;
                if (ridx < total) CS_D_IN = rq[ridx];
                @(negedge sysclk);
            end
        end
        bus.RD_READY = 1'b0;
        check_eq("rd_done_seen", 32'(done_seen), 1);
        if (stall) check_eq("stall_cycles", 32'(stalled), 10);
        rq.delete();
    endtask

    task automatic wait_strobe(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge sysclk);
            bus.WD_VALID = bus.WD_READY || bus.WD_VALID;
            if (!WCSTB_n) seen = 1'b1;
        end
        bus.WD_VALID = 1'b0;
    endtask

    initial begin
        logic seen;
        bus.CMD_VALID = 0; bus.CMD_WRITE = 0; bus.CMD_ADDR = 0; bus.CMD_COUNT = 0;
        bus.WD_VALID = 0; bus.WD = 0; bus.RD_READY = 0;
        #3 check_reset_vals("por");
        repeat (2) @(negedge sysclk);
        sys_rst = 1'b0;
        @(negedge sysclk);
        check_reset_vals("idle");

        wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        do_write(12'h7FF, 8'd1, 0);
        do_write(12'hFFF, 8'd2, 30);

        rq = '{16'hA5A5, 16'h0001, 16'h0002, 16'h0003};
        do_read(12'h010, 8'd1, 0, 1'b1);

        issue_cmd(1'b1, 12'h345, 8'd2);
        bus.WD = 16'hBEEF;
        wait_strobe(seen);
        check_eq("abort_strobe_seen", 32'(seen), 1);
        ABORT = 1'b1;
        @(negedge sysclk);
        ABORT = 1'b0;
        check_eq("abort_stb2", 32'(WCSTB_n), 0);
        @(negedge sysclk);
        check_eq("abort_hold_stb", 32'(WCSTB_n), 1);
        check_eq("abort_hold_busy", 32'(BUSY), 1);
        check_eq("abort_hold_done", 32'(DONE), 0);
        @(negedge sysclk);
        check_eq("abort_done", 32'(DONE), 1);
        check_eq("abort_idle", 32'(bus.CMD_READY), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            check_eq("abort_no_wd_ready", 32'(bus.WD_READY), 0);
        end

        issue_cmd(1'b1, 12'h123, 8'd3);
        bus.WD = 16'h5A5A;
        wait_strobe(seen);
        check_eq("rst_strobe_seen", 32'(seen), 1);
        #2 sys_rst = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge sysclk);
        sys_rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            do_write(12'($urandom), 8'($urandom_range(1, 4)), 25);
            do_read(12'($urandom), 8'($urandom_range(1, 3)), 40, 1'b0);
        end

        do_write(12'($urandom), 8'd0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
